// File: rtl/fabric_uart_tx.sv
// 8-bit UART transmitter: start bit, 8 data bits LSB first, optional parity, 1 or 2 stop bits.
// Every output is a flop; the next value is decided one cycle early by the FSM's comb process.
module fabric_uart_tx #(
   parameter int CLKS_PER_BIT = 868,
   parameter int STOP_BITS    = 1,
   parameter int PARITY       = 0
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic       txd,
   output logic       busy,
   output logic       tx_done
);

   localparam int                CNT_W      = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(CLKS_PER_BIT - 1);
   localparam bit                PARITY_EN  = (PARITY != 0);
   localparam logic              PARITY_ODD = (PARITY == 2);
   localparam logic              STOP_LAST  = 1'(STOP_BITS - 1);

   if (CLKS_PER_BIT < 2 || CLKS_PER_BIT > 65535) begin : g_bad_clks_per_bit
      $error("fabric_uart_tx: CLKS_PER_BIT must be in 2..65535");
   end
   if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
      $error("fabric_uart_tx: STOP_BITS must be 1 or 2");
   end
   if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
      $error("fabric_uart_tx: PARITY must be 0, 1 or 2");
   end

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [2:0]        idx_q, idx_d;
   logic              stop_q, stop_d;
   logic [7:0]        shift_q, shift_d;
   logic              par_q, par_d;
   logic              txd_d, ready_d, busy_d, done_d;
   logic              bit_end;

   assign bit_end = (cnt_q == CNT_LAST);

   // NOTE: every signal gets its default before the case, so no path can infer a latch.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      stop_d  = stop_q;
      shift_d = shift_q;
      par_d   = par_q;
      txd_d   = txd;
      ready_d = tx_ready;
      busy_d  = busy;
      done_d  = 1'b0;

      // The bit timer free-runs through a frame and wraps at every bit boundary.
      if (state_q != ST_IDLE) begin
         cnt_d = bit_end ? '0 : cnt_q + CNT_W'(1);
      end

      unique case (state_q)
         ST_IDLE: begin
            if (tx_valid && tx_ready) begin
               state_d = ST_START;
               shift_d = tx_data;
               par_d   = (^tx_data) ^ PARITY_ODD;
               cnt_d   = '0;
               idx_d   = '0;
               stop_d  = 1'b0;
               txd_d   = 1'b0;
               ready_d = 1'b0;
               busy_d  = 1'b1;
            end
         end

         ST_START: begin
            if (bit_end) begin
               state_d = ST_DATA;
               txd_d   = shift_q[0];
            end
         end

         ST_DATA: begin
            if (bit_end) begin
               if (idx_q == 3'd7) begin
                  if (PARITY_EN) begin
                     state_d = ST_PARITY;
                     txd_d   = par_q;
                  end else begin
                     state_d = ST_STOP;
                     txd_d   = 1'b1;
                  end
               end else begin
                  idx_d   = idx_q + 3'd1;
                  shift_d = shift_q >> 1;
                  txd_d   = shift_q[1];
               end
            end
         end

         ST_PARITY: begin
            if (bit_end) begin
               state_d = ST_STOP;
               txd_d   = 1'b1;
            end
         end

         ST_STOP: begin
            if (bit_end) begin
               if (stop_q == STOP_LAST) begin
                  state_d = ST_IDLE;
                  txd_d   = 1'b1;
                  ready_d = 1'b1;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
               end else begin
                  stop_d = 1'b1;
               end
            end
         end

         default: begin
            state_d = ST_IDLE;
            txd_d   = 1'b1;
            ready_d = 1'b1;
            busy_d  = 1'b0;
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         idx_q    <= '0;
         stop_q   <= 1'b0;
         shift_q  <= '0;
         par_q    <= 1'b0;
         txd      <= 1'b1;
         tx_ready <= 1'b1;
         busy     <= 1'b0;
         tx_done  <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         idx_q    <= idx_d;
         stop_q   <= stop_d;
         shift_q  <= shift_d;
         par_q    <= par_d;
         txd      <= txd_d;
         tx_ready <= ready_d;
         busy     <= busy_d;
         tx_done  <= done_d;
      end
   end

endmodule

// File: tb/tb_fabric_uart_tx.sv
// Bench for fabric_uart_tx: four configurations, expected frames queued at stimulus time and
// compared cycle by cycle by one monitor per instance.
module tb_fabric_uart_tx;

   typedef struct {
      int          inst;
      logic [11:0] frame;   // bit 0 goes on the line first
      int          nbits;
      bit          abort;
      int          gap;     // expected cycles since previous handshake, 0 = unchecked
   } exp_t;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [3:0] tx_valid = '0;
   logic [7:0] tx_data [4];
   logic [3:0] tx_ready, txd, busy, tx_done;

   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;
   exp_t exp_q[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic expect_frame(input int inst, input logic [11:0] frame, input int nbits,
                               input bit abort, input int gap);
      exp_t e;
      e.inst  = inst;
      e.frame = frame;
      e.nbits = nbits;
      e.abort = abort;
      e.gap   = gap;
      exp_q.push_back(e);
   endtask

   // Inst 0: 4 clk/bit, no parity. 1: even. 2: odd. 3: 3 clk/bit, two stop bits.
   for (genvar g = 0; g < 4; g++) begin : g_dut
      localparam int CPB = (g == 3) ? 3 : 4;
      localparam int PAR = (g == 1) ? 1 : ((g == 2) ? 2 : 0);
      localparam int SB  = (g == 3) ? 2 : 1;

      fabric_uart_tx #(
         .CLKS_PER_BIT (CPB),
         .STOP_BITS    (SB),
         .PARITY       (PAR)
      ) u_dut (
         .clk      (clk),
         .reset    (reset),
         .tx_data  (tx_data[g]),
         .tx_valid (tx_valid[g]),
         .tx_ready (tx_ready[g]),
         .txd      (txd[g]),
         .busy     (busy[g]),
         .tx_done  (tx_done[g])
      );

      initial begin : mon
         exp_t       e;
         int         c;
         int         flen;
         int         last_hs;
         bit         active;
         bit         ok;
         logic [3:0] obs;
         c       = 0;
         flen    = 0;
         last_hs = 0;
         active  = 1'b0;
         @(negedge reset);
         forever begin
            @(negedge clk);
            obs = {txd[g], busy[g], tx_ready[g], tx_done[g]};
            if (active) begin
               c++;
               if (c <= flen)
                  check($sformatf("u%0d frame cyc %0d txd/busy/ready/done", g, c), 32'(obs),
                        {28'd0, e.frame[(c - 1) / CPB], 3'b100});
               if (reset && c <= flen) begin
                  check($sformatf("u%0d frame aborted by reset", g), 32'(e.abort), 32'd1);
                  active = 1'b0;
               end else if (c == flen + 1) begin
                  check($sformatf("u%0d frame end txd/busy/ready/done", g), 32'(obs), 32'hB);
                  check($sformatf("u%0d frame completed", g), 32'(e.abort), 32'd0);
                  active = 1'b0;
               end
            end else begin
               check($sformatf("u%0d idle txd/busy/ready/done", g), 32'(obs), 32'hA);
            end
            if (!active && !reset && tx_valid[g] && tx_ready[g]) begin
               ok = (exp_q.size() > 0) && (exp_q[0].inst == g);
               check($sformatf("u%0d handshake expected", g), 32'(ok), 32'd1);
               if (ok) begin
                  e = exp_q.pop_front();
                  if (e.gap != 0)
                     check($sformatf("u%0d handshake spacing", g), cyc - last_hs, e.gap);
                  last_hs = cyc;
                  flen    = e.nbits * CPB;
                  c       = 0;
                  active  = 1'b1;
               end
            end
         end
      end
   end

   // Returns just after the handshake edge; tx_valid must already be high.
   task automatic wait_hs(input int k);
      bit got = 1'b0;
      for (int i = 0; i < 200 && !got; i++) begin
         @(negedge clk);
         got = tx_ready[k] && !reset;
      end
      check($sformatf("u%0d handshake within budget", k), 32'(got), 32'd1);
      @(posedge clk);
      #1;
   endtask

   task automatic send(input int k, input logic [7:0] d, input bit toggle);
      @(posedge clk);
      #1;
      tx_data[k]  = d;
      tx_valid[k] = 1'b1;
      wait_hs(k);
      tx_valid[k] = 1'b0;
      if (toggle) begin
         for (int i = 0; i < 12; i++) begin
            tx_data[k] = ~tx_data[k];
            repeat (3) @(posedge clk);
            #1;
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 4; i++) tx_data[i] = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      check("u0 reset state txd/busy/ready/done",
            32'({txd[0], busy[0], tx_ready[0], tx_done[0]}), 32'hA);

      // 0xA5, with tx_data toggling while the frame is on the line.
      expect_frame(0, 10'b1101001010, 10, 1'b0, 0);
      send(0, 8'hA5, 1'b1);
      repeat (20) @(posedge clk);

      // Idle stall: nothing may move.
      repeat (100) @(posedge clk);
      @(negedge clk);
      check("u0 after stall txd/busy/done", 32'({txd[0], busy[0], tx_done[0]}), 32'h4);

      // Back-to-back with tx_valid held: 0x00 then 0xFF, 41 cycles apart.
      expect_frame(0, 10'b1000000000, 10, 1'b0, 0);
      expect_frame(0, 10'b1111111110, 10, 1'b0, 41);
      @(posedge clk);
      #1;
      tx_data[0]  = 8'h00;
      tx_valid[0] = 1'b1;
      wait_hs(0);
      tx_data[0] = 8'hFF;
      wait_hs(0);
      tx_valid[0] = 1'b0;
      repeat (50) @(posedge clk);

      // Parity on 0x07: even gives 1, odd gives 0; 11 bit periods each.
      expect_frame(1, 11'b11000001110, 11, 1'b0, 0);
      send(1, 8'h07, 1'b0);
      repeat (50) @(posedge clk);
      expect_frame(2, 11'b10000001110, 11, 1'b0, 0);
      send(2, 8'h07, 1'b0);
      repeat (50) @(posedge clk);

      // Two stop bits, 3 clk/bit, 0x81: done 33 cycles after the handshake.
      expect_frame(3, 11'b11100000010, 11, 1'b0, 0);
      send(3, 8'h81, 1'b0);
      repeat (45) @(posedge clk);

      // Reset during data bit 3 of 0x3C, then a clean 0x55.
      expect_frame(0, 10'b1001111000, 10, 1'b1, 0);
      send(0, 8'h3C, 1'b0);
      repeat (17) @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      check("u0 after abort txd/busy/ready/done",
            32'({txd[0], busy[0], tx_ready[0], tx_done[0]}), 32'hA);
      expect_frame(0, 10'b1010101010, 10, 1'b0, 0);
      send(0, 8'h55, 1'b0);
      repeat (50) @(posedge clk);

      // tx_valid while reset is high must not be accepted.
      #1;
      reset       = 1'b1;
      tx_data[1]  = 8'hAA;
      tx_valid[1] = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      reset       = 1'b0;
      tx_valid[1] = 1'b0;
      @(negedge clk);
      check("u1 no handshake under reset busy/ready", 32'({busy[1], tx_ready[1]}), 32'h1);
      repeat (10) @(posedge clk);

      check("all expected frames seen", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
